// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
// Streaming RV32I instruction encoder (inverse of the decode stage). Decoded
// field bundles are accepted over a valid/ready handshake and packed into
// 32-bit instruction words through a two-stage pipeline. Each word is tagged
// with a sequential byte address. Illegal bundles produce NOP_WORD with err_o.
//
// Ports:
//   clock, reset_n           : clock, synchronous active-low reset
//   start_i, base_addr_i,
//   count_i                  : begin a load sequence of count_i words (IDLE only)
//   busy_o, done_o           : sequence running / one-cycle completion pulse
//   in_valid_i, in_ready_o   : field bundle handshake
//   format_i, op_i, funct_3_i,
//   funct_7_i, rd_i, rs1_i,
//   rs2_i, imm_i             : decoded instruction fields
//   out_valid_o, out_ready_i : encoded word handshake
//   instr_o, addr_o, err_o   : encoded word, its byte address, illegal flag
//   err_cnt_o                : illegal words in this sequence (saturating)
// ----------------------------------------------------------------------------
module instr_encoder #(
    parameter int          ADDR_W   = 32,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  count_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        format_i,
    input  logic [6:0]        op_i,
    input  logic [2:0]        funct_3_i,
    input  logic [6:0]        funct_7_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [31:0]       imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  err_cnt_o
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_base, r_index;
    logic [CNT_W-1:0]  r_remaining, r_err_cnt;

    // Stage 1: captured fields, address and legality
    logic              r_s1_valid, r_s1_illegal;
    logic [2:0]        r_s1_fmt, r_s1_f3;
    logic [6:0]        r_s1_op, r_s1_f7;
    logic [4:0]        r_s1_rd, r_s1_rs1, r_s1_rs2;
    logic [31:0]       r_s1_imm;
    logic [ADDR_W-1:0] r_s1_addr;

    // Stage 2: output word
    logic              r_s2_valid, r_s2_err;
    logic [31:0]       r_s2_instr;
    logic [ADDR_W-1:0] r_s2_addr;

    logic              w_out_fire, w_s2_adv, w_s2_load, w_in_ready, w_in_fire;
    logic              w_last_out, w_op_known, w_imm_ok, w_in_legal;
    logic [2:0]        w_fmt_want;
    logic [31:0]       w_enc;
    logic [ADDR_W-1:0] w_in_addr;

    // Stage 2 can take a new word when empty or when its word is leaving.
    assign w_out_fire = r_s2_valid && out_ready_i;
    assign w_s2_adv   = !r_s2_valid || out_ready_i;
    assign w_s2_load  = w_s2_adv && r_s1_valid;
    assign w_in_ready = (r_state == S_RUN) && (r_remaining != '0) &&
                        (!r_s1_valid || w_s2_adv);
    assign w_in_fire  = in_valid_i && w_in_ready;
    assign w_in_addr  = r_base + (r_index << 2);
    // Last word leaving: nothing left to accept and nothing behind it.
    assign w_last_out = (r_remaining == '0) && !r_s1_valid && w_out_fire;

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: default first so no path leaves the signal unassigned
        // (which would infer a latch).
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = (count_i != '0) ? S_RUN : S_DONE;
            S_RUN:   if (w_last_out) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- Legality of the incoming bundle ----------------
    always_comb begin
        w_op_known = 1'b0;
        w_fmt_want = FMT_R;
        case (op_i)
            7'b0110011:                         begin w_op_known = 1'b1; w_fmt_want = FMT_R; end
            7'b0010011, 7'b0000011, 7'b1100111: begin w_op_known = 1'b1; w_fmt_want = FMT_I; end
            7'b0100011:                         begin w_op_known = 1'b1; w_fmt_want = FMT_S; end
            7'b1100011:                         begin w_op_known = 1'b1; w_fmt_want = FMT_B; end
            7'b0110111, 7'b0010111:             begin w_op_known = 1'b1; w_fmt_want = FMT_U; end
            7'b1101111:                         begin w_op_known = 1'b1; w_fmt_want = FMT_J; end
            default: ;
        endcase

        w_imm_ok = 1'b1;
        case (format_i)
            FMT_B, FMT_J: w_imm_ok = !imm_i[0];
            FMT_U:        w_imm_ok = (imm_i[11:0] == 12'h000);
            FMT_I, FMT_S: w_imm_ok = (imm_i[31:12] == {20{imm_i[11]}});
            default: ;
        endcase

        // Formats 6/7 never match any expected format, so they fail here.
        w_in_legal = w_op_known && (format_i == w_fmt_want) && w_imm_ok;
    end

    // ---------------- Field packing from stage 1 ----------------
    always_comb begin
        w_enc = {25'b0, r_s1_op};
        case (r_s1_fmt)
            FMT_R: w_enc = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
            FMT_I: w_enc = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
            FMT_S: w_enc = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                            r_s1_imm[4:0], r_s1_op};
            FMT_B: w_enc = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1,
                            r_s1_f3, r_s1_imm[4:1], r_s1_imm[11], r_s1_op};
            FMT_U: w_enc = {r_s1_imm[31:12], r_s1_rd, r_s1_op};
            FMT_J: w_enc = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11],
                            r_s1_imm[19:12], r_s1_rd, r_s1_op};
            default: ;
        endcase
    end

    // ---------------- Sequence control ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_base      <= '0;
            r_index     <= '0;
            r_remaining <= '0;
            r_err_cnt   <= '0;
        end else if (r_state == S_IDLE && start_i) begin
            r_base      <= base_addr_i;
            r_index     <= '0;
            r_remaining <= count_i;
            r_err_cnt   <= '0;
        end else begin
            if (w_in_fire) begin
                r_remaining <= r_remaining - CNT_W'(1);
                r_index     <= r_index + ADDR_W'(1);
            end
            // Counted as the word enters the output stage, so err_cnt_o
            // already includes the word currently shown on instr_o.
            if (w_s2_load && r_s1_illegal && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    // ---------------- Pipeline ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            // NOTE: data registers are reset too, because every output,
            // including instr_o/addr_o, must read zero out of reset.
            r_s1_valid   <= 1'b0;
            r_s1_illegal <= 1'b0;
            r_s1_fmt     <= '0;
            r_s1_op      <= '0;
            r_s1_f3      <= '0;
            r_s1_f7      <= '0;
            r_s1_rd      <= '0;
            r_s1_rs1     <= '0;
            r_s1_rs2     <= '0;
            r_s1_imm     <= '0;
            r_s1_addr    <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_err     <= 1'b0;
            r_s2_instr   <= '0;
            r_s2_addr    <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid   <= 1'b1;
                r_s1_illegal <= !w_in_legal;
                r_s1_fmt     <= format_i;
                r_s1_op      <= op_i;
                r_s1_f3      <= funct_3_i;
                r_s1_f7      <= funct_7_i;
                r_s1_rd      <= rd_i;
                r_s1_rs1     <= rs1_i;
                r_s1_rs2     <= rs2_i;
                r_s1_imm     <= imm_i;
                r_s1_addr    <= w_in_addr;
            end else if (w_s2_adv) begin
                r_s1_valid   <= 1'b0;
            end

            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_instr <= r_s1_illegal ? NOP_WORD : w_enc;
                    r_s2_err   <= r_s1_illegal;
                    r_s2_addr  <= r_s1_addr;
                end
            end
        end
    end

    assign busy_o      = (r_state == S_RUN);
    assign done_o      = (r_state == S_DONE);
    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_s2_valid;
    assign instr_o     = r_s2_instr;
    assign addr_o      = r_s2_addr;
    assign err_o       = r_s2_err;
    assign err_cnt_o   = r_err_cnt;

endmodule
